// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide stage feeding the register file write port.
// Optional macro MULDIV_EARLY_OUT_EN: zero-cycle path for trivial operands.
module muldiv_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [2:0]        FUNCT,
   input  logic [XLEN-1:0]   OPA,
   input  logic [XLEN-1:0]   OPB,
   input  logic [ADDR_W-1:0] DEST,
   output logic              BUSY,
   output logic              WB_WRITE,
   output logic [ADDR_W-1:0] WB_ADDR,
   output logic [XLEN-1:0]   WB_DATA
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state;
   logic [2:0]        fn;
   logic [ADDR_W-1:0] dst;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   hi;
   logic [XLEN-1:0]   lo;
   logic              neg_a;
   logic              neg_b;
   logic [CW-1:0]     cnt;

   logic              sgn_a_in;
   logic              sgn_b_in;
   logic [XLEN-1:0]   mag_a_in;
   logic [XLEN-1:0]   mag_b_in;

   logic [XLEN:0]     sum;
   logic [XLEN:0]     shr;
   logic              ge;
   logic [XLEN-1:0]   diff;
   logic [XLEN-1:0]   nxt_hi;
   logic [XLEN-1:0]   nxt_lo;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] sprod;
   logic [XLEN-1:0]   q_res;
   logic [XLEN-1:0]   r_mag;
   logic [XLEN-1:0]   r_res;
   logic [XLEN-1:0]   result;

   // Operand signedness and magnitudes at the accepting edge
   always_comb begin
      sgn_a_in = (FUNCT != 3'b011) && (FUNCT != 3'b101) && (FUNCT != 3'b111);
      sgn_b_in = sgn_a_in && (FUNCT != 3'b010);
      mag_a_in = (sgn_a_in && OPA[XLEN-1]) ? -OPA : OPA;
      mag_b_in = (sgn_b_in && OPB[XLEN-1]) ? -OPB : OPB;
   end

   // One shift-add or restoring shift-subtract step, plus final fix-up
   always_comb begin
      sum    = {1'b0, hi} + {1'b0, (lo[0] ? mag_a : {XLEN{1'b0}})};
      shr    = {hi, lo[XLEN-1]};
      ge     = shr >= {1'b0, mag_b};
      diff   = shr[XLEN-1:0] - mag_b;
      nxt_hi = '0;
      nxt_lo = '0;
      if (fn[2]) begin
         nxt_hi = ge ? diff : shr[XLEN-1:0];
         nxt_lo = {lo[XLEN-2:0], ge};
      end else begin
         nxt_hi = sum[XLEN:1];
         nxt_lo = {sum[0], lo[XLEN-1:1]};
      end
      prod  = {nxt_hi, nxt_lo};
      sprod = (neg_a ^ neg_b) ? -prod : prod;
      if (mag_b == '0) begin
         q_res = '1;
         r_mag = mag_a;
      end else begin
         q_res = (neg_a ^ neg_b) ? -nxt_lo : nxt_lo;
         r_mag = nxt_hi;
      end
      r_res = neg_a ? -r_mag : r_mag;
      if (fn[2])
         result = fn[1] ? r_res : q_res;
      else if (fn[1:0] == 2'b00)
         result = sprod[XLEN-1:0];
      else
         result = sprod[2*XLEN-1:XLEN];
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic            early;
   logic [XLEN-1:0] early_res;
   logic            div0;
   logic            ovf;
   logic            mz;

   // Trivial operand detection for the zero-cycle path
   always_comb begin
      div0 = FUNCT[2] && (OPB == '0);
      ovf  = FUNCT[2] && !FUNCT[0] &&
             (OPA == {1'b1, {(XLEN-1){1'b0}}}) && (OPB == '1);
      mz   = !FUNCT[2] && ((OPA == '0) || (OPB == '0));
      early = div0 || ovf || mz;
      early_res = '0;
      if (div0)
         early_res = FUNCT[1] ? OPA : '1;
      else if (ovf)
         early_res = FUNCT[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end
`endif

   // Control FSM, datapath registers and registered write-back
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state    <= IDLE;
         fn       <= '0;
         dst      <= '0;
         mag_a    <= '0;
         mag_b    <= '0;
         hi       <= '0;
         lo       <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         cnt      <= '0;
         BUSY     <= 1'b0;
         WB_WRITE <= 1'b0;
         WB_ADDR  <= '0;
         WB_DATA  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (START) begin
                  fn    <= FUNCT;
                  dst   <= DEST;
                  mag_a <= mag_a_in;
                  mag_b <= mag_b_in;
                  neg_a <= sgn_a_in && OPA[XLEN-1];
                  neg_b <= sgn_b_in && OPB[XLEN-1];
                  hi    <= '0;
                  lo    <= FUNCT[2] ? mag_a_in : mag_b_in;
                  cnt   <= '0;
                  BUSY  <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                  if (early) begin
                     state    <= DONE;
                     WB_WRITE <= 1'b1;
                     WB_DATA  <= early_res;
                     WB_ADDR  <= DEST;
                  end else begin
                     state <= CALC;
                  end
`else
                  state <= CALC;
`endif
               end
            end
            CALC: begin
               hi  <= nxt_hi;
               lo  <= nxt_lo;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(XLEN-1)) begin
                  state    <= DONE;
                  WB_WRITE <= 1'b1;
                  WB_DATA  <= result;
                  WB_ADDR  <= dst;
               end
            end
            DONE: begin
               WB_WRITE <= 1'b0;
               BUSY     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit multiply/divide execution stage, directly downstream of the CPU register file read ports and upstream of its write port.
- Accepts two operands read from the register file, a 3-bit operation code and a destination register address.
- Computes the RV32M-style result over multiple cycles.
- Issues a single-cycle write-back (data, address, write strobe) that connects straight to the register file's IN/INADDRESS/WRITE inputs.

Parameters:
XLEN, 32, operand/result width (design verified at 32 only)
ADDR_W, 5, destination register address width

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-low reset
START  input  1  request; accepted only when BUSY=0
FUNCT  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
OPA  input  XLEN  operand A (rs1 / dividend / multiplicand)
OPB  input  XLEN  operand B (rs2 / divisor / multiplier)
DEST  input  ADDR_W  destination register address
BUSY  output  1  high while an operation is in flight (state != IDLE)
WB_WRITE  output  1  one-cycle write strobe to the register file
WB_ADDR  output  ADDR_W  write-back register address
WB_DATA  output  XLEN  write-back result

Behaviour:
- Reset (RESET=0 at a rising edge): state=IDLE, BUSY=0, WB_WRITE=0, WB_ADDR=0, WB_DATA=0, iteration counter=0, internal datapath cleared.
- All outputs are registered.
- States: IDLE, CALC, DONE.
- IDLE:
  - START=1 at edge N latches FUNCT, DEST, the operand magnitudes and the sign flags, clears the counter, and moves to CALC.
  - BUSY=1 from edge N.
- CALC:
  - One iteration per edge, N+1..N+32 (counter 0..31).
  - Multiply: unsigned shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract on magnitudes, producing quotient and remainder.
  - At edge N+32: sign fix-up and result select are applied, WB_DATA/WB_ADDR are loaded, WB_WRITE=1, state moves to DONE.
- DONE:
  - Edge N+33: WB_WRITE=0, state moves to IDLE, BUSY=0.
  - WB_DATA/WB_ADDR hold their last value.
  - A new START is accepted at edge N+34 or later.
- Latency: exactly 32 cycles from the START edge to the WB_WRITE edge; WB_WRITE is high for exactly one cycle.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: OPA signed, OPB unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
- Multiply result:
  - 64-bit product is negated if the operand signs differ.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide result:
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Divisor = 0: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = OPA (REM and REMU).
- Signed overflow (OPA=0x80000000, OPB=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- Both special cases still take the full 32-cycle path unless the optional feature is enabled.
- START while BUSY=1 is ignored; no queueing, and the in-flight operands are unaffected.
- RESET=0 mid-operation: the operation is abandoned, the next state is IDLE, and no WB_WRITE is generated.
- Operands, FUNCT and DEST are only sampled on the accepting edge; they may change freely afterwards.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: divide-by-zero, signed division overflow, and multiply with either operand 0 skip CALC.
  - At the accepting edge N the unit goes IDLE to DONE with the final result loaded and WB_WRITE=1.
  - At edge N+1 it returns to IDLE with WB_WRITE=0.
  - Latency is 0 cycles, and results are identical to the iterative path.
- Undefined: every operation takes the full 32-cycle path, and no early-out detection logic is present.

Test Plan:
1. MUL, OPA=7, OPB=0xFFFFFFFD, DEST=5 -> WB_WRITE high exactly one cycle, 32 edges after the START edge; WB_DATA=0xFFFFFFEB, WB_ADDR=5; BUSY low one edge later.
2. OPA=OPB=0xFFFFFFFF -> MULHU=0xFFFFFFFE, MULH=0x00000000, MULHSU=0xFFFFFFFF, MUL=0x00000001.
3. DIV/REM of OPA=0xFFFFFFF9 (-7), OPB=2 -> 0xFFFFFFFD / 0xFFFFFFFF; DIVU/REMU 100 by 7 -> 0x0000000E / 0x00000002.
4. DIV 0x12345678 by 0 -> 0xFFFFFFFF; REMU same operands -> 0x12345678; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000, REM -> 0; each takes 32 cycles with the macro undefined and 0 cycles with it defined.
5. START MUL 3*4 DEST=2, then a second START (DIV, DEST=9) pulsed 10 cycles later -> single write-back only: WB_DATA=0x0000000C, WB_ADDR=2; the second request is dropped.
6. START DIVU, then RESET=0 for one edge at counter=15 -> BUSY=0 and WB_WRITE=0 after that edge, WB_DATA=0, no write-back ever; a subsequent START executes normally.
